uart_reg_arbiter: RTL and testbench
===================================

UART_REG_ARBITER -- requirements
Module: uart_reg_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 5: register address width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32: register data width.
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 16: downstream ack timeout in clk_i cycles.
REQ-004 The block SHALL have port clk_i  input  1: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst_i  input  1: reset, synchronous and active-high.
REQ-006 The block SHALL have port req_i  input  2: per-requester request; bit n is requester n.
REQ-007 The block SHALL have port addr_i  input  2*ADDR_WIDTH: per-requester address; slice n is requester n.
REQ-008 The block SHALL have port we_i  input  2: per-requester write enable.
REQ-009 The block SHALL have port wdata_i  input  2*DATA_WIDTH: per-requester write data.
REQ-010 The block SHALL have port strb_i  input  2*(DATA_WIDTH/8): per-requester byte strobe.
REQ-011 The block SHALL have port ack_o  output  2: one-cycle completion pulse to requester n.
REQ-012 The block SHALL have port rdata_o  output  DATA_WIDTH: read data, valid while any ack_o bit is 1.
REQ-013 The block SHALL have port resp_o  output  1: error flag, valid while any ack_o bit is 1.
REQ-014 The block SHALL have ports mreq_o, maddr_o, mwe_o, mwdata_o and mstrb_o  output  1, ADDR_WIDTH, 1, DATA_WIDTH, DATA_WIDTH/8: downstream register-file request.
REQ-015 The block SHALL have ports mack_i, mrdata_i and mresp_i  input  1, DATA_WIDTH, 1: downstream acknowledge, read data and error.

Function
REQ-016 The FSM SHALL have three states: IDLE, ISSUE and RESP; it SHALL hold exactly one transaction in flight.
REQ-017 In IDLE, when any req_i bit is 1, the block SHALL grant one requester, register that requester's addr, we, wdata and strb into the downstream output registers, and enter ISSUE at the next edge.
REQ-018 Arbitration SHALL be round-robin through a 1-bit priority pointer: with both bits requesting, the pointer selects; with one bit requesting, that requester wins.
REQ-019 After each grant the pointer SHALL point to the non-granted requester.
REQ-020 In ISSUE, mreq_o SHALL be 1 with the registered fields stable.
REQ-021 In ISSUE, when mack_i is 1, the block SHALL capture mrdata_i and mresp_i, drop mreq_o, and enter RESP at the next edge.
REQ-022 In RESP, the granted requester's ack_o bit SHALL be 1 for exactly one cycle, with the captured rdata_o and resp_o; the FSM SHALL then return to IDLE.
REQ-023 With a combinational downstream ack, latency SHALL be 3 cycles from request sample (IDLE) to ack_o pulse.
REQ-024 Requesters SHALL hold req and their fields stable until ack; a req_i bit still 1 in IDLE after its ack SHALL be treated as a new transaction.
REQ-025 The block SHALL ignore changes to req_i outside IDLE; the non-granted requester SHALL wait without loss.
REQ-026 rdata_o SHALL be 0 for writes and for error responses.
REQ-027 mwdata_o and mstrb_o SHALL pass through unmodified; the block SHALL not decode addresses.

Reset
REQ-028 While rst_i is 1 at an edge, the FSM SHALL go to IDLE and the pointer to 0.
REQ-029 While rst_i is 1 at an edge, all outputs SHALL be 0, including every downstream register.
REQ-030 Reset mid-transaction SHALL abort the transaction without any ack_o pulse.

Configuration
REQ-031 With macro UART_REG_ARB_TIMEOUT_EN defined, a counter SHALL count ISSUE cycles without mack_i; at TIMEOUT_CYCLES it SHALL drop mreq_o, enter RESP with resp_o=1 and rdata_o=0, and clear on leaving ISSUE.
REQ-032 Without UART_REG_ARB_TIMEOUT_EN, the counter SHALL be absent and ISSUE SHALL wait indefinitely for mack_i.

Verification
REQ-033 Requester 0 reads addr 0x04 while the downstream returns 0x28B0, resp 0 -> ack_o=01 on the 3rd cycle, rdata_o=0x28B0, resp_o=0.
REQ-034 Both requesters assert on the same cycle after reset -> requester 0 is acked first, then requester 1; both stay asserted again -> order 0,1,0,1.
REQ-035 Requester 1 writes 0xA5 to 0x00 with strb 0xF -> in ISSUE, maddr_o=0x00, mwe_o=1, mwdata_o=0xA5, mstrb_o=0xF; then ack_o=10 and rdata_o=0.
REQ-036 Downstream returns mresp_i=1 -> resp_o=1 with the ack pulse; the next transaction returns resp_o=0.
REQ-037 rst_i is pulsed while in ISSUE -> no ack_o pulse, all outputs 0, next request is granted to requester 0.
REQ-038 With UART_REG_ARB_TIMEOUT_EN defined and mack_i held 0 -> ack with resp_o=1 after 16 ISSUE cycles; without the macro -> no ack after 100 cycles.

Source files
------------

// File: rtl/uart_reg_arbiter.sv
// Two-requester round-robin arbiter in front of a register-file port, one transaction in flight.
// Optional downstream ack timeout enabled by defining UART_REG_ARB_TIMEOUT_EN.
module uart_reg_arbiter #(
  parameter int unsigned ADDR_WIDTH     = 5,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [1:0]                    req_i,
  input  logic [2*ADDR_WIDTH-1:0]       addr_i,
  input  logic [1:0]                    we_i,
  input  logic [2*DATA_WIDTH-1:0]       wdata_i,
  input  logic [2*(DATA_WIDTH/8)-1:0]   strb_i,
  output logic [1:0]                    ack_o,
  output logic [DATA_WIDTH-1:0]         rdata_o,
  output logic                          resp_o,
  output logic                          mreq_o,
  output logic [ADDR_WIDTH-1:0]         maddr_o,
  output logic                          mwe_o,
  output logic [DATA_WIDTH-1:0]         mwdata_o,
  output logic [(DATA_WIDTH/8)-1:0]     mstrb_o,
  input  logic                          mack_i,
  input  logic [DATA_WIDTH-1:0]         mrdata_i,
  input  logic                          mresp_i
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_e;

  state_e state_q, state_d;

  logic                  ptr_q, ptr_d;
  logic                  gnt_q, gnt_d;
  logic                  mreq_d;
  logic [ADDR_WIDTH-1:0] maddr_d;
  logic                  mwe_d;
  logic [DATA_WIDTH-1:0] mwdata_d;
  logic [STRB_WIDTH-1:0] mstrb_d;
  logic [1:0]            ack_d;
  logic [DATA_WIDTH-1:0] rdata_d;
  logic                  resp_d;

  logic                  any_req_c;
  logic                  gnt_idx_c;
  logic                  timeout_hit_c;

  if (TIMEOUT_CYCLES == 0) begin : g_cfg_check
    $error("uart_reg_arbiter: TIMEOUT_CYCLES must be at least 1");
  end

  // Round-robin pick: pointer breaks ties, a lone requester always wins.
  assign any_req_c = |req_i;
  assign gnt_idx_c = (&req_i) ? ptr_q : req_i[1];

`ifdef UART_REG_ARB_TIMEOUT_EN
  localparam int unsigned CNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_WIDTH-1:0] tmo_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tmo_cnt_q <= '0;
    end else if (state_q == ISSUE && !mack_i && !timeout_hit_c) begin
      tmo_cnt_q <= tmo_cnt_q + CNT_WIDTH'(1);
    end else begin
      tmo_cnt_q <= '0;
    end
  end

  assign timeout_hit_c = (state_q == ISSUE) && !mack_i &&
                         (tmo_cnt_q == CNT_WIDTH'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit_c = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (any_req_c) state_d = ISSUE;
      ISSUE:   if (mack_i || timeout_hit_c) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs and arbitration state.
  always_comb begin
    ptr_d    = ptr_q;
    gnt_d    = gnt_q;
    mreq_d   = mreq_o;
    maddr_d  = maddr_o;
    mwe_d    = mwe_o;
    mwdata_d = mwdata_o;
    mstrb_d  = mstrb_o;
    ack_d    = 2'b00;
    rdata_d  = rdata_o;
    resp_d   = resp_o;
    unique case (state_q)
      IDLE: begin
        if (any_req_c) begin
          gnt_d    = gnt_idx_c;
          ptr_d    = ~gnt_idx_c;
          mreq_d   = 1'b1;
          maddr_d  = gnt_idx_c ? addr_i[2*ADDR_WIDTH-1:ADDR_WIDTH] : addr_i[ADDR_WIDTH-1:0];
          mwe_d    = gnt_idx_c ? we_i[1] : we_i[0];
          mwdata_d = gnt_idx_c ? wdata_i[2*DATA_WIDTH-1:DATA_WIDTH] : wdata_i[DATA_WIDTH-1:0];
          mstrb_d  = gnt_idx_c ? strb_i[2*STRB_WIDTH-1:STRB_WIDTH] : strb_i[STRB_WIDTH-1:0];
        end
      end
      ISSUE: begin
        if (mack_i) begin
          mreq_d  = 1'b0;
          ack_d   = gnt_q ? 2'b10 : 2'b01;
          resp_d  = mresp_i;
          rdata_d = (mwe_o || mresp_i) ? '0 : mrdata_i;
        end else if (timeout_hit_c) begin
          mreq_d  = 1'b0;
          ack_d   = gnt_q ? 2'b10 : 2'b01;
          resp_d  = 1'b1;
          rdata_d = '0;
        end
      end
      RESP: begin
        rdata_d = '0;
        resp_d  = 1'b0;
      end
      default: begin
        mreq_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q    <= 1'b0;
      gnt_q    <= 1'b0;
      mreq_o   <= 1'b0;
      maddr_o  <= '0;
      mwe_o    <= 1'b0;
      mwdata_o <= '0;
      mstrb_o  <= '0;
      ack_o    <= 2'b00;
      rdata_o  <= '0;
      resp_o   <= 1'b0;
    end else begin
      ptr_q    <= ptr_d;
      gnt_q    <= gnt_d;
      mreq_o   <= mreq_d;
      maddr_o  <= maddr_d;
      mwe_o    <= mwe_d;
      mwdata_o <= mwdata_d;
      mstrb_o  <= mstrb_d;
      ack_o    <= ack_d;
      rdata_o  <= rdata_d;
      resp_o   <= resp_d;
    end
  end

endmodule

// File: tb/tb_uart_reg_arbiter.sv
// Scoreboard bench for uart_reg_arbiter; define UART_REG_ARB_TIMEOUT_EN to exercise the timeout build.
module tb_uart_reg_arbiter;

  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = DW / 8;

  typedef struct {
    logic [1:0]    ack;
    logic [DW-1:0] rdata;
    logic          resp;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic [1:0]        req;
  logic [2*AW-1:0]   addr;
  logic [1:0]        we;
  logic [2*DW-1:0]   wdata;
  logic [2*SW-1:0]   strb;
  logic [1:0]        ack;
  logic [DW-1:0]     rdata;
  logic              resp;
  logic              mreq;
  logic [AW-1:0]     maddr;
  logic              mwe;
  logic [DW-1:0]     mwdata;
  logic [SW-1:0]     mstrb;
  logic              mack;
  logic [DW-1:0]     mrdata;
  logic              mresp;

  // Downstream model: combinational ack, read data tagged with the address.
  logic              ds_ack_en;
  logic [DW-1:0]     ds_rdata;
  logic              ds_resp;
  assign mack   = mreq & ds_ack_en;
  assign mrdata = ds_rdata ^ DW'(maddr);
  assign mresp  = ds_resp;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  uart_reg_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(16)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .addr_i(addr), .we_i(we),
    .wdata_i(wdata), .strb_i(strb), .ack_o(ack), .rdata_o(rdata), .resp_o(resp),
    .mreq_o(mreq), .maddr_o(maddr), .mwe_o(mwe), .mwdata_o(mwdata), .mstrb_o(mstrb),
    .mack_i(mack), .mrdata_i(mrdata), .mresp_i(mresp)
  );

  function automatic exp_t mk_exp(input int n, input logic w, input logic [AW-1:0] a,
                                  input logic [DW-1:0] rd, input logic rsp);
    exp_t e;
    e.ack   = (n == 0) ? 2'b01 : 2'b10;
    e.rdata = (w || rsp) ? '0 : (rd ^ DW'(a));
    e.resp  = rsp;
    return e;
  endfunction

  task automatic drive_req(input int n, input logic w, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic [SW-1:0] s);
    if (n == 0) begin
      addr[AW-1:0] = a; we[0] = w; wdata[DW-1:0] = d; strb[SW-1:0] = s;
    end else begin
      addr[2*AW-1:AW] = a; we[1] = w; wdata[2*DW-1:DW] = d; strb[2*SW-1:SW] = s;
    end
    req[n] = 1'b1;
  endtask

  // Scoreboard: every ack pulse must match the oldest expected response.
  always @(negedge clk) begin
    if (rst !== 1'b1 && ack !== 2'b00) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_ack ack_o=%b rdata_o=%h resp_o=%b", ack, rdata, resp);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (ack !== e.ack || rdata !== e.rdata || resp !== e.resp) begin
          errors++;
          $display("FAIL sb_response got ack=%b rdata=%h resp=%b want ack=%b rdata=%h resp=%b",
                   ack, rdata, resp, e.ack, e.rdata, e.resp);
        end
      end
    end
  end

  task automatic test_reset;
    rst = 1'b1; req = '0; addr = '0; we = '0; wdata = '0; strb = '0;
    ds_ack_en = 1'b1; ds_rdata = '0; ds_resp = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (ack !== 2'b00) begin errors++; $display("FAIL reset_ack got=%b want=00", ack); end
    checks++;
    if (rdata !== '0 || resp !== 1'b0) begin
      errors++; $display("FAIL reset_resp got rdata=%h resp=%b want 0", rdata, resp);
    end
    checks++;
    if (mreq !== 1'b0 || maddr !== '0 || mwe !== 1'b0 || mwdata !== '0 || mstrb !== '0) begin
      errors++;
      $display("FAIL reset_downstream got mreq=%b maddr=%h mwe=%b mwdata=%h mstrb=%h want 0",
               mreq, maddr, mwe, mwdata, mstrb);
    end
    rst = 1'b0;
  endtask

  task automatic test_read_latency;
    int cyc;
    cyc = -1;
    @(posedge clk); #1;
    ds_rdata = 32'h0000_28B4; ds_resp = 1'b0;
    sb.push_back(mk_exp(0, 1'b0, 5'h04, ds_rdata, 1'b0));
    drive_req(0, 1'b0, 5'h04, 32'h0, 4'h0);
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (i == 2) begin
        checks++;
        if (mreq !== 1'b1 || maddr !== 5'h04 || mwe !== 1'b0) begin
          errors++; $display("FAIL read_issue got mreq=%b maddr=%h mwe=%b want 1 04 0", mreq, maddr, mwe);
        end
      end
      if (ack[0] === 1'b1) begin cyc = i; break; end
    end
    checks++;
    if (cyc != 3) begin errors++; $display("FAIL read_latency got=%0d want=3", cyc); end
    checks++;
    if (rdata !== 32'h0000_28B0 || resp !== 1'b0) begin
      errors++; $display("FAIL read_data got rdata=%h resp=%b want 000028b0 0", rdata, resp);
    end
    req[0] = 1'b0;
  endtask

  task automatic test_write;
    int cyc;
    cyc = -1;
    @(posedge clk); #1;
    ds_rdata = 32'hDEAD_BEEF; ds_resp = 1'b0;
    sb.push_back(mk_exp(1, 1'b1, 5'h00, ds_rdata, 1'b0));
    drive_req(1, 1'b1, 5'h00, 32'h0000_00A5, 4'hF);
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (i == 2) begin
        checks++;
        if (mreq !== 1'b1 || maddr !== 5'h00 || mwe !== 1'b1 || mwdata !== 32'h0000_00A5 || mstrb !== 4'hF) begin
          errors++;
          $display("FAIL write_issue got mreq=%b maddr=%h mwe=%b mwdata=%h mstrb=%h want 1 00 1 000000a5 f",
                   mreq, maddr, mwe, mwdata, mstrb);
        end
      end
      if (ack[1] === 1'b1) begin cyc = i; break; end
    end
    checks++;
    if (cyc != 3 || ack !== 2'b10 || rdata !== '0) begin
      errors++; $display("FAIL write_ack got cyc=%0d ack=%b rdata=%h want 3 10 0", cyc, ack, rdata);
    end
    req[1] = 1'b0;
  endtask

  task automatic test_error_resp;
    int cyc;
    for (int t = 0; t < 2; t++) begin
      cyc = -1;
      @(posedge clk); #1;
      ds_rdata = 32'h0000_1234; ds_resp = (t == 0);
      sb.push_back(mk_exp(0, 1'b0, AW'(7 + t), ds_rdata, ds_resp));
      drive_req(0, 1'b0, AW'(7 + t), 32'h0, 4'h0);
      for (int i = 1; i <= 60; i++) begin
        @(negedge clk);
        if (ack[0] === 1'b1) begin cyc = i; break; end
      end
      checks++;
      if (cyc < 0 || resp !== (t == 0)) begin
        errors++; $display("FAIL error_resp_%0d got cyc=%0d resp=%b want resp=%0d", t, cyc, resp, (t == 0));
      end
      req[0] = 1'b0;
    end
    ds_resp = 1'b0;
  endtask

  task automatic test_hold_other;
    int  seen;
    logic stable;
    seen = 0; stable = 1'b1;
    @(posedge clk); #1;
    ds_ack_en = 1'b0; ds_rdata = 32'h0BAD_0000;
    sb.push_back(mk_exp(0, 1'b0, 5'h02, ds_rdata, 1'b0));
    sb.push_back(mk_exp(1, 1'b0, 5'h05, ds_rdata, 1'b0));
    drive_req(0, 1'b0, 5'h02, 32'h0, 4'h0);
    repeat (2) @(negedge clk);
    drive_req(1, 1'b0, 5'h05, 32'h0, 4'h0);
    repeat (5) begin
      @(negedge clk);
      if (mreq !== 1'b1 || maddr !== 5'h02) stable = 1'b0;
    end
    checks++;
    if (stable !== 1'b1) begin errors++; $display("FAIL hold_issue_stable got=%b want=1", stable); end
    ds_ack_en = 1'b1;
    for (int i = 1; i <= 60 && seen < 2; i++) begin
      @(negedge clk);
      if (ack[0] === 1'b1) begin req[0] = 1'b0; seen++; end
      if (ack[1] === 1'b1) begin req[1] = 1'b0; seen++; end
    end
    checks++;
    if (seen != 2) begin errors++; $display("FAIL hold_both_served got=%0d want=2", seen); end
    req = '0;
  endtask

  task automatic test_round_robin;
    int k;
    k = 0;
    @(negedge clk); rst = 1'b1; @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    ds_rdata = 32'h0000_7700;
    for (int j = 0; j < 4; j++)
      sb.push_back(mk_exp(j % 2, 1'b0, (j % 2 == 0) ? 5'h03 : 5'h09, ds_rdata, 1'b0));
    drive_req(0, 1'b0, 5'h03, 32'h0, 4'h0);
    drive_req(1, 1'b0, 5'h09, 32'h0, 4'h0);
    for (int i = 1; i <= 80 && k < 4; i++) begin
      @(negedge clk);
      if (ack !== 2'b00) begin
        checks++;
        if (ack !== ((k % 2 == 0) ? 2'b01 : 2'b10)) begin
          errors++; $display("FAIL rr_order_%0d got=%b want=%b", k, ack, (k % 2 == 0) ? 2'b01 : 2'b10);
        end
        k++;
        if (k == 4) req = '0;
      end
    end
    checks++;
    if (k != 4) begin errors++; $display("FAIL rr_count got=%0d want=4", k); end
    req = '0;
  endtask

  task automatic test_timeout;
    int   issue_cyc;
    logic got;
    issue_cyc = 0; got = 1'b0;
    @(posedge clk); #1;
    ds_ack_en = 1'b0;
`ifdef UART_REG_ARB_TIMEOUT_EN
    sb.push_back(mk_exp(0, 1'b0, 5'h01, ds_rdata, 1'b1));
    drive_req(0, 1'b0, 5'h01, 32'h0, 4'h0);
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (ack[0] === 1'b1) begin got = 1'b1; break; end
      if (mreq === 1'b1) issue_cyc++;
    end
    checks++;
    if (got !== 1'b1 || issue_cyc != 16 || resp !== 1'b1 || rdata !== '0) begin
      errors++;
      $display("FAIL timeout_ack got ack=%b issue_cycles=%0d resp=%b rdata=%h want 1 16 1 0",
               got, issue_cyc, resp, rdata);
    end
    req[0] = 1'b0;
`else
    drive_req(0, 1'b0, 5'h01, 32'h0, 4'h0);
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (ack !== 2'b00) got = 1'b1;
    end
    checks++;
    if (got !== 1'b0 || mreq !== 1'b1) begin
      errors++; $display("FAIL no_timeout got ack_seen=%b mreq=%b want 0 1", got, mreq);
    end
    req = '0; rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
`endif
  endtask

  task automatic test_reset_mid;
    logic any_ack;
    logic [1:0] first;
    int   seen;
    any_ack = 1'b0; first = 2'b00; seen = 0;
    @(posedge clk); #1;
    ds_ack_en = 1'b0; ds_rdata = 32'h0000_5500;
    drive_req(0, 1'b1, 5'h06, 32'hCAFE_F00D, 4'h3);
    repeat (3) @(negedge clk);
    checks++;
    if (mreq !== 1'b1) begin errors++; $display("FAIL mid_in_issue got mreq=%b want 1", mreq); end
    rst = 1'b1; req = '0;
    @(negedge clk);
    checks++;
    if (ack !== 2'b00 || rdata !== '0 || resp !== 1'b0 || mreq !== 1'b0 || maddr !== '0 ||
        mwe !== 1'b0 || mwdata !== '0 || mstrb !== '0) begin
      errors++;
      $display("FAIL mid_reset_outputs got ack=%b rdata=%h resp=%b mreq=%b maddr=%h mwe=%b mwdata=%h mstrb=%h want 0",
               ack, rdata, resp, mreq, maddr, mwe, mwdata, mstrb);
    end
    rst = 1'b0;
    ds_ack_en = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (ack !== 2'b00) any_ack = 1'b1;
    end
    checks++;
    if (any_ack !== 1'b0) begin errors++; $display("FAIL mid_reset_no_ack got=%b want=0", any_ack); end
    @(posedge clk); #1;
    sb.push_back(mk_exp(0, 1'b0, 5'h03, ds_rdata, 1'b0));
    sb.push_back(mk_exp(1, 1'b0, 5'h09, ds_rdata, 1'b0));
    drive_req(0, 1'b0, 5'h03, 32'h0, 4'h0);
    drive_req(1, 1'b0, 5'h09, 32'h0, 4'h0);
    for (int i = 1; i <= 60 && seen < 2; i++) begin
      @(negedge clk);
      if (ack !== 2'b00) begin
        if (seen == 0) first = ack;
        if (ack[0] === 1'b1) req[0] = 1'b0;
        if (ack[1] === 1'b1) req[1] = 1'b0;
        seen++;
      end
    end
    checks++;
    if (first !== 2'b01 || seen != 2) begin
      errors++; $display("FAIL mid_reset_ptr got first=%b served=%0d want 01 2", first, seen);
    end
    req = '0;
  endtask

  initial begin
    test_reset();
    test_read_latency();
    test_write();
    test_error_resp();
    test_hold_other();
    test_round_robin();
    test_timeout();
    test_reset_mid();
    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL sb_drained got=%0d want=0", sb.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
